arb_wrr: RTL
============

Name: arb_wrr

Overview:
Parametrised weighted round-robin arbiter with a valid/ready grant handshake. It arbitrates WIDTH requesters onto one downstream port. Each requester gets up to its programmed weight of consecutive accepted transfers before priority rotates. A pending grant is held stable under backpressure. It sits in the common arbiter library as the next generation of the plain round-robin arbiter, for shared-bus and NoC port muxing.

Parameters:
WIDTH, 4, number of requesters (>=2)
WGT_W, 4, bit width of each per-requester weight and of the credit counter
IDX_W, $clog2(WIDTH), width of gnt_idx (derived, not overridden)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req  input  WIDTH  per-requester request; must stay high until accepted
req_wgt  input  WIDTH*WGT_W  weight of requester i in bits [i*WGT_W +: WGT_W]; quasi-static
req_last  input  WIDTH  per-requester last-beat flag; used only with ARB_WRR_LOCK_EN
gnt_rdy  input  1  downstream accepts the current grant
gnt  output  WIDTH  one-hot grant
gnt_vld  output  1  any grant active (OR of gnt)
gnt_idx  output  IDX_W  binary index of the granted requester; 0 when gnt_vld=0

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- State registers:
  - ptr (IDX_W): highest-priority index.
  - cnt (WGT_W): transfers already credited to ptr.
  - hold_vld, hold_idx: pending unaccepted grant.
  - lock_vld, lock_idx: used only with the optional feature.
- Reset values: ptr=0, cnt=0, hold_vld=0, lock_vld=0.
- Outputs are combinational from state and req, with zero-cycle latency. req=0 gives gnt=0, gnt_vld=0, gnt_idx=0.
- Selection, in priority order:
  - If hold_vld=1 and req[hold_idx]=1, grant hold_idx.
  - Otherwise, grant the first i with req[i]=1 scanning cyclically ptr, ptr+1, ... WIDTH-1, 0, ... ptr-1.
- A hold whose requester has dropped req is a protocol violation. The arbiter releases it and re-arbitrates in the same cycle.
- Transfer occurs when gnt_vld & gnt_rdy.
- Hold update:
  - gnt_vld=1 & gnt_rdy=0: hold_vld<=1, hold_idx<=granted index.
  - Transfer: hold_vld<=0.
- ptr and cnt change only on a transfer.
- Credit update on a transfer to index g:
  - w = req_wgt[g], with w=0 treated as 1.
  - base = (g==ptr) ? cnt : 0; n = base+1.
  - If n >= w: ptr <= (g==WIDTH-1) ? 0 : g+1, and cnt <= 0.
  - Else: ptr <= g, and cnt <= n.
- Weight is sampled at the transfer cycle. A weight lowered below cnt causes rotation on the next transfer.
- cnt never exceeds 2^WGT_W-1. The n>=w compare is evaluated WGT_W+1 bits wide, so it never wraps.
- No starvation: every continuously requesting channel is granted within sum over all requesters of max(w,1) transfers.

Optional Feature:
Macro ARB_WRR_LOCK_EN (packet lock).
- Defined:
  - A transfer with req_last[g]=0 sets lock_vld<=1, lock_idx<=g.
  - While lock_vld=1, the grant goes only to lock_idx; if req[lock_idx]=0, gnt=0.
  - Lock has priority over hold and the scan.
  - ptr/cnt update only on transfers with req_last[g]=1; that transfer also clears lock_vld. Weight therefore counts packets.
- Undefined: req_last is ignored; every transfer counts as a packet; lock registers are absent.

Test Plan:
1. WIDTH=4, weights {ch0..ch3}={1,2,1,3}, req=4'b1111, gnt_rdy=1 for 14 cycles -> gnt_idx sequence 0,1,1,2,3,3,3,0,1,1,2,3,3,3.
2. Weights all 1, req=4'b1010, gnt_rdy=1 -> gnt_idx 1,3,1,3; req=0 -> gnt=0, gnt_vld=0, gnt_idx=0, ptr unchanged.
3. req=4'b0110, gnt_rdy=0 for 3 cycles, then req[3] also rises with ptr moved externally impossible -> gnt stays 4'b0010 all 3 cycles; gnt_rdy=1 -> transfer on ch1, next grant ch2 (w=1).
4. req_wgt[ch2]=0, req=4'b0100 for 3 transfers -> each transfer sets ptr=3, cnt=0, i.e. weight 0 behaves as 1.
5. ptr=3, cnt=2 (ch3 w=3 mid-burst), rst_n pulsed low asynchronously -> ptr=0, cnt=0, hold cleared immediately; with req=4'b1111, gnt=4'b0001 during and after reset.
6. ARB_WRR_LOCK_EN, weights all 1, req=4'b0011, ch0 sends 3 beats with req_last=0,0,1 -> gnt_idx 0,0,0 then 1; without the macro -> 0,1,0,1.

Source files
------------

// File: rtl/arb_wrr.sv
// Weighted round-robin arbiter, WIDTH requesters onto one port; ARB_WRR_LOCK_EN enables packet lock.
// Latency: grant is combinational from req and state (zero cycles); credit/pointer update on transfer.
// Backpressure: an unaccepted grant is held stable while gnt_rdy=0 and its requester keeps req high.
module arb_wrr #(
    parameter int WIDTH = 4,
    parameter int WGT_W = 4,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         req,
    input  logic [WIDTH*WGT_W-1:0]   req_wgt,
    input  logic [WIDTH-1:0]         req_last,
    input  logic                     gnt_rdy,
    output logic [WIDTH-1:0]         gnt,
    output logic                     gnt_vld,
    output logic [IDX_W-1:0]         gnt_idx
);

    logic [IDX_W-1:0] ptr;
    logic [WGT_W-1:0] cnt;
    logic             hold_vld;
    logic [IDX_W-1:0] hold_idx;
`ifdef ARB_WRR_LOCK_EN
    logic             lock_vld;
    logic [IDX_W-1:0] lock_idx;
`endif

    logic             scan_vld;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] scan_pos;
    int               scan_sum;
    logic             sel_vld;
    logic [IDX_W-1:0] sel_idx;

    logic [WGT_W-1:0] wgt_raw;
    logic [WGT_W:0]   wgt_eff;
    logic [WGT_W:0]   credit_n;
    logic             rotate;
    logic [IDX_W-1:0] ptr_next;
    logic             xfer;
    logic             pkt_end;

    // Cyclic scan starting at ptr; first requester found wins.
    always_comb begin
        scan_vld = 1'b0;
        scan_idx = '0;
        scan_pos = '0;
        scan_sum = 0;
        for (int k = 0; k < WIDTH; k++) begin
            scan_sum = int'(ptr) + k;
            if (scan_sum >= WIDTH) begin
                scan_sum = scan_sum - WIDTH;
            end
            scan_pos = IDX_W'(scan_sum);
            if (!scan_vld && req[scan_pos]) begin
                scan_vld = 1'b1;
                scan_idx = scan_pos;
            end
        end
    end

    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
`ifdef ARB_WRR_LOCK_EN
        if (lock_vld) begin
            sel_vld = req[lock_idx];
            sel_idx = req[lock_idx] ? lock_idx : '0;
        end else
`endif
        if (hold_vld && req[hold_idx]) begin
            sel_vld = 1'b1;
            sel_idx = hold_idx;
        end else begin
            sel_vld = scan_vld;
            sel_idx = scan_idx;
        end
    end

    always_comb begin
        gnt = '0;
        if (sel_vld) begin
            gnt[sel_idx] = 1'b1;
        end
    end

    assign gnt_vld = sel_vld;
    assign gnt_idx = sel_idx;
    assign xfer    = sel_vld & gnt_rdy;

    always_comb begin
        wgt_raw = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                wgt_raw = req_wgt[i*WGT_W +: WGT_W];
            end
        end
    end

    // One bit wider than the counter so the compare cannot wrap; zero weight acts as one.
    assign wgt_eff  = (wgt_raw == '0) ? (WGT_W+1)'(1) : {1'b0, wgt_raw};
    assign credit_n = ((sel_idx == ptr) ? {1'b0, cnt} : '0) + (WGT_W+1)'(1);
    assign rotate   = (credit_n >= wgt_eff);
    assign ptr_next = (sel_idx == IDX_W'(WIDTH-1)) ? '0 : sel_idx + IDX_W'(1);

`ifdef ARB_WRR_LOCK_EN
    assign pkt_end = req_last[sel_idx];
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign pkt_end     = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            cnt      <= '0;
            hold_vld <= 1'b0;
            hold_idx <= '0;
`ifdef ARB_WRR_LOCK_EN
            lock_vld <= 1'b0;
            lock_idx <= '0;
`endif
        end else begin
            // A hold whose requester dropped is released here since sel_vld re-arbitrates.
            hold_vld <= sel_vld & ~gnt_rdy;
            if (sel_vld && !gnt_rdy) begin
                hold_idx <= sel_idx;
            end
            if (xfer && pkt_end) begin
                if (rotate) begin
                    ptr <= ptr_next;
                    cnt <= '0;
                end else begin
                    ptr <= sel_idx;
                    cnt <= credit_n[WGT_W-1:0];
                end
            end
`ifdef ARB_WRR_LOCK_EN
            if (xfer) begin
                lock_vld <= ~req_last[sel_idx];
                if (!req_last[sel_idx]) begin
                    lock_idx <= sel_idx;
                end
            end
`endif
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_vld_or:     assert property (@(posedge clk) disable iff (!rst_n) gnt_vld == (|gnt));
    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (gnt_vld && !gnt_rdy) |=> ((gnt == $past(gnt)) || !(|($past(gnt) & req))));

endmodule
